// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle main control FSM and the datapath.
// The master is the control FSM. It receives the opcode and the memory
// handshake, and it drives every control line plus its debug state.
// The slave is the datapath/memory side.
interface multicycle_control_fsm_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
) ();
  // Memory handshake:
  //   - mem_read/mem_write request an access and stay high for as long as
  //     the FSM sits in an access state.
  //   - The memory raises mem_ready in the cycle that the access completes.
  //   - The FSM leaves the access state on the clock edge that ends that
  //     cycle, so a request is never withdrawn before it is acknowledged.
  //   - mem_ready has no meaning while no request is raised.
  logic [OP_W-1:0]    instr_op;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source;
  logic               illegal_op;
  logic               retire;
  logic [CNT_W-1:0]   retire_cnt;
  logic [3:0]         state;

  modport master (
    input  instr_op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, retire, retire_cnt, state
  );

  modport slave (
    output instr_op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, retire, retire_cnt, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control.
// A Moore FSM steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
// It drives the mux selects, the write enables and the ALU op class for one
// shared ALU and one shared memory. Memory accesses stall on mem_ready.
// retire_cnt counts completed instructions and wraps silently.
// Optional feature: define JUMP_EN to decode opcode 000010 as a jump.
// Without JUMP_EN, opcode 000010 is illegal and the JUMP state is never entered.
module multicycle_control_fsm #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  state_t            state_q;
  logic [OP_W-1:0]   op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              jump_op;

  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source;
  logic               illegal_op;
  logic               retire;

`ifdef JUMP_EN
  assign jump_op = (bus.instr_op == OP_J);
`else
  assign jump_op = 1'b0;
`endif

  // State register plus the opcode latched in DECODE. MEM_ADDR uses the
  // latched opcode to choose between the read and the write path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH:    if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          op_q <= bus.instr_op;
          if (bus.instr_op == OP_RTYPE)                          state_q <= S_EXEC;
          else if (bus.instr_op == OP_LW || bus.instr_op == OP_SW) state_q <= S_MEM_ADDR;
          else if (bus.instr_op == OP_BEQ)                       state_q <= S_BRANCH;
          else if (bus.instr_op == OP_ADDI)                      state_q <= S_ADDI_EX;
          else if (jump_op)                                      state_q <= S_JUMP;
          else                                                   state_q <= S_FETCH;
        end
        S_MEM_ADDR: state_q <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready) state_q <= S_MEM_WB;
        S_MEM_WR:   if (bus.mem_ready) state_q <= S_FETCH;
        S_EXEC:     state_q <= S_R_WB;
        S_ADDI_EX:  state_q <= S_ADDI_WB;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the control lines. mem_ready only gates the FETCH load
  // and the retire of a store. Holding rst forces every line to 0, so a
  // reset in mid-instruction cannot leave a partial write behind.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = '0;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    retire        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = bus.mem_ready;
          pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = !((bus.instr_op == OP_RTYPE) || (bus.instr_op == OP_LW) ||
                         (bus.instr_op == OP_SW) || (bus.instr_op == OP_BEQ) ||
                         (bus.instr_op == OP_ADDI) || jump_op);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = bus.mem_ready;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_W'(2'b10);
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_W'(2'b01);
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          retire        = 1'b1;
        end
`ifdef JUMP_EN
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          retire    = 1'b1;
        end
`endif
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Retired-instruction counter. It advances on the edge that ends a
  // retire cycle and wraps to 0 without any flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.illegal_op    = illegal_op;
  assign bus.retire        = retire;
  assign bus.retire_cnt    = cnt_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. The counter is built 4 bits wide so
// that the wrap happens within a short run.
// Each instruction pushes its expected per-cycle {state, control vector}
// sequence. Per-cycle inputs go into a matching stimulus queue, and the
// queues are drained one clock at a time.
module tb_multicycle_control_fsm;
  localparam int OP_W    = 6;
  localparam int ALUOP_W = 2;
  localparam int CNT_W   = 4;
  localparam int W       = 22;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [W-1:0]     exp_q[$];
  logic [2:0]       stim_q[$];
  logic [CNT_W-1:0] exp_cnt;
  logic [17:0]      obs_ctrl;

  multicycle_control_fsm_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  multicycle_control_fsm #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign obs_ctrl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source, bus.illegal_op, bus.retire};

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector, in the same bit order as obs_ctrl.
  function automatic logic [17:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rdst, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] psrc,
                                     input logic ill, input logic ret);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill, ret};
  endfunction

  function automatic logic [17:0] v_fetch(input logic rdy);
    return mk(rdy, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
  endfunction
  function automatic logic [17:0] v_decode(input logic ill);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, ill, 0);
  endfunction
  function automatic logic [17:0] v_memwr(input logic rdy);
    return mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, rdy);
  endfunction

  localparam logic [17:0] V_MEM_ADDR = 18'b0000000001_10_00_00_0_0;
  localparam logic [17:0] V_MEM_RD   = 18'b0011000000_00_00_00_0_0;
  localparam logic [17:0] V_MEM_WB   = 18'b0000001010_00_00_00_0_1;
  localparam logic [17:0] V_EXEC     = 18'b0000000001_00_10_00_0_0;
  localparam logic [17:0] V_R_WB     = 18'b0000000110_00_00_00_0_1;
  localparam logic [17:0] V_BRANCH   = 18'b0100000001_00_01_01_0_1;
  localparam logic [17:0] V_JUMP     = 18'b1000000000_00_00_10_0_1;
  localparam logic [17:0] V_ADDI_EX  = 18'b0000000001_10_00_00_0_0;
  localparam logic [17:0] V_ADDI_WB  = 18'b0000000010_00_00_00_0_1;
  localparam logic [17:0] V_ZERO     = 18'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: rdy 0/1 drives mem_ready, 2 drives a random value (don't care).
  // dec selects the real opcode; other cycles see a random opcode.
  task automatic push(input logic [3:0] st, input logic [17:0] c,
                      input logic [1:0] rdy, input logic dec);
    exp_q.push_back({st, c});
    stim_q.push_back({dec, rdy});
  endtask

  task automatic drain(input string tag, input logic [5:0] op);
    logic [2:0]   s;
    logic [W-1:0] e;
    int           n;
    n = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      bus.mem_ready = (s[1:0] == 2'd2) ? 1'($urandom_range(0, 1)) : s[0];
      bus.instr_op  = s[2] ? op : 6'($urandom_range(0, 63));
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s.cyc%0d.state_ctrl", tag, n), {10'b0, bus.state, obs_ctrl}, {10'b0, e});
      chk($sformatf("%s.cyc%0d.retire_cnt", tag, n), {28'b0, bus.retire_cnt}, {28'b0, exp_cnt});
      if (e[0]) exp_cnt++;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_rtype(input string tag);
    push(4'd0, v_fetch(1), 2'd1, 0);
    push(4'd1, v_decode(0), 2'd2, 1);
    push(4'd6, V_EXEC, 2'd2, 0);
    push(4'd7, V_R_WB, 2'd2, 0);
    drain(tag, 6'b000000);
  endtask

  task automatic do_lw(input string tag, input int stalls);
    push(4'd0, v_fetch(1), 2'd1, 0);
    push(4'd1, v_decode(0), 2'd2, 1);
    push(4'd2, V_MEM_ADDR, 2'd2, 0);
    for (int i = 0; i < stalls; i++) push(4'd3, V_MEM_RD, 2'd0, 0);
    push(4'd3, V_MEM_RD, 2'd1, 0);
    push(4'd4, V_MEM_WB, 2'd2, 0);
    drain(tag, 6'b100011);
  endtask

  task automatic do_sw(input string tag, input int stalls);
    push(4'd0, v_fetch(1), 2'd1, 0);
    push(4'd1, v_decode(0), 2'd2, 1);
    push(4'd2, V_MEM_ADDR, 2'd2, 0);
    for (int i = 0; i < stalls; i++) push(4'd5, v_memwr(0), 2'd0, 0);
    push(4'd5, v_memwr(1), 2'd1, 0);
    drain(tag, 6'b101011);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = '0;
    rst      = 1'b1;
    bus.instr_op  = '0;
    bus.mem_ready = 1'b0;

    // reset state: all controls 0 while rst is high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.state", {28'b0, bus.state}, 32'd0);
    chk("reset.ctrl", {14'b0, obs_ctrl}, {14'b0, V_ZERO});
    chk("reset.retire_cnt", {28'b0, bus.retire_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // R-type, 4 cycles, retire_cnt 0 -> 1
    do_rtype("rtype");

    // lw with mem_ready low for 3 cycles in MEM_RD, 8 cycles in total
    do_lw("lw_stall", 3);

    // beq, then sw back-to-back with the store stalled twice
    push(4'd0, v_fetch(1), 2'd1, 0);
    push(4'd1, v_decode(0), 2'd2, 1);
    push(4'd8, V_BRANCH, 2'd2, 0);
    drain("beq", 6'b000100);
    do_sw("sw_stall", 2);

    // unknown opcode: illegal_op pulse in DECODE, back to FETCH, no retire
    push(4'd0, v_fetch(1), 2'd1, 0);
    push(4'd1, v_decode(1), 2'd2, 1);
    drain("illegal", 6'b111111);

    // jump opcode
    push(4'd0, v_fetch(1), 2'd1, 0);
`ifdef JUMP_EN
    push(4'd1, v_decode(0), 2'd2, 1);
    push(4'd9, V_JUMP, 2'd2, 0);
`else
    push(4'd1, v_decode(1), 2'd2, 1);
`endif
    drain("jump", 6'b000010);

    // addi, with a one-cycle stall in FETCH first
    push(4'd0, v_fetch(0), 2'd0, 0);
    push(4'd0, v_fetch(1), 2'd1, 0);
    push(4'd1, v_decode(0), 2'd2, 1);
    push(4'd10, V_ADDI_EX, 2'd2, 0);
    push(4'd11, V_ADDI_WB, 2'd2, 0);
    drain("addi", 6'b001000);

    // 16 more retires push the 4-bit counter through its wrap
    for (int i = 0; i < 16; i++) do_rtype($sformatf("wrap%0d", i));

    // reset asserted mid-MEM_RD: asynchronous return to FETCH, outputs 0
    push(4'd0, v_fetch(1), 2'd1, 0);
    push(4'd1, v_decode(0), 2'd2, 1);
    push(4'd2, V_MEM_ADDR, 2'd2, 0);
    drain("lw_pre_rst", 6'b100011);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid.before_state", {28'b0, bus.state}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.state", {28'b0, bus.state}, 32'd0);
    chk("rst_mid.ctrl", {14'b0, obs_ctrl}, {14'b0, V_ZERO});
    chk("rst_mid.retire_cnt", {28'b0, bus.retire_cnt}, 32'd0);
    exp_cnt = '0;
    @(posedge clk);
    #1;
    chk("rst_mid.held_ctrl", {14'b0, obs_ctrl}, {14'b0, V_ZERO});
    rst = 1'b0;

    // recovery after reset
    do_rtype("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
